// File: rtl/accel_sched_pkg.sv
// Shared types and sizing helpers for the accelerometer sample scheduler.
package accel_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StRequest,
    StWaitDone,
    StCommit,
    StError
  } sched_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned calc_period(input int unsigned clk_hz,
                                              input int unsigned rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running period divider: one-cycle tick every PERIOD cycles while enabled.
module rate_tick_gen
  import accel_sched_pkg::*;
#(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CntW = cnt_width(PERIOD);
  localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero while disabled so the first tick lands PERIOD cycles after enable.
  always_comb begin
    cnt_d = '0;
    if (i_enable && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_enable && (cnt_q == LastCnt);

endmodule

// File: rtl/accel_sample_scheduler.sv
// Per-period SPI read sequencer with timeout/retry supervision and averaging-window counting.
module accel_sample_scheduler
  import accel_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ = 100,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned WINDOW         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  output logic                      o_SPI_Start,
  input  logic                      i_SPI_Done,
  output logic                      o_AVG_dataReady,
  output logic                      o_SCH_WindowDone,
  output logic [$clog2(WINDOW)-1:0] o_SCH_SampleCount,
  output logic                      o_SCH_Overrun,
  output logic                      o_SCH_Timeout,
  output logic                      o_SCH_Error,
  output logic                      o_SCH_Busy
);

  localparam int unsigned PERIOD = calc_period(CLK_FREQ_HZ, SAMPLE_RATE_HZ);
  localparam int unsigned ToW    = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned RetryW = cnt_width(RETRY_MAX + 1);
  localparam int unsigned CountW = $clog2(WINDOW);

  localparam logic [ToW-1:0]    ToLast     = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(RETRY_MAX);
  localparam logic [CountW-1:0] CountLast  = CountW'(WINDOW - 1);

  sched_state_e      state_q;
  logic [ToW-1:0]    to_cnt_q;
  logic [RetryW-1:0] retry_q;
  logic [RetryW-1:0] retry_inc;
  logic [CountW-1:0] count_q;
  logic              start_q, ready_q, wdone_q, error_q, busy_q;
  logic              tick;
  logic              timeout_hit;

  rate_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  // Done in the expiry cycle takes priority, so expiry is qualified by !i_SPI_Done.
  assign timeout_hit = (state_q == StWaitDone) && !i_SPI_Done && (to_cnt_q == ToLast);
  assign retry_inc   = retry_q + RetryW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
      retry_q  <= '0;
      count_q  <= '0;
      start_q  <= 1'b0;
      ready_q  <= 1'b0;
      wdone_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ready_q <= 1'b0;
      wdone_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_enable) state_q <= StWaitTick;
        end
        StWaitTick: begin
          if (!i_enable) begin
            state_q <= StIdle;
          end else if (tick) begin
            state_q <= StRequest;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRequest: begin
          to_cnt_q <= '0;
          state_q  <= StWaitDone;
        end
        StWaitDone: begin
          if (i_SPI_Done) begin
            state_q <= StCommit;
            retry_q <= '0;
            ready_q <= 1'b1;
            if (count_q == CountLast) begin
              count_q <= '0;
              wdone_q <= 1'b1;
            end else begin
              count_q <= count_q + CountW'(1);
            end
          end else if (timeout_hit) begin
            retry_q <= retry_inc;
            if (retry_inc >= RetryLimit) begin
              state_q <= StError;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (i_enable) begin
              state_q <= StRequest;
              start_q <= 1'b1;
            end else begin
              // Disabled mid-retry: abandon the sample rather than re-request.
              state_q <= StIdle;
              retry_q <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StCommit: begin
          busy_q  <= 1'b0;
          state_q <= i_enable ? StWaitTick : StIdle;
        end
        StError: begin
          if (!i_enable) begin
            state_q <= StIdle;
            error_q <= 1'b0;
            retry_q <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_SPI_Start       = start_q;
  assign o_AVG_dataReady   = ready_q;
  assign o_SCH_WindowDone  = wdone_q;
  assign o_SCH_SampleCount = count_q;
  assign o_SCH_Error       = error_q;
  assign o_SCH_Busy        = busy_q;
  assign o_SCH_Timeout     = timeout_hit;
  // ERROR ignores ticks entirely, so it does not report them as dropped.
  assign o_SCH_Overrun     = tick && (state_q != StWaitTick) && (state_q != StError);

endmodule
